id_ex_stage: RTL and testbench

- Decode-to-execute pipeline register of the 5-stage RV32I core.
- Captures the register-file read data and decoded control from the decode stage.
- Applies the writeback-to-decode bypass, because the register file writes at the clock edge and reads combinationally.
- Detects load-use hazards, inserts bubbles, and handles the execute-stage stall and flush.

---
 rtl/id_ex_stage.sv | 160 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RV32I core: writeback bypass, load-use bubble, execute stall/flush.
// Optional HAZARD_CNT_EN build adds 32-bit lu_cnt / flush_cnt hazard counters.
module id_ex_stage #(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [XLEN-1:0]    pc_D,
  input  logic [XLEN-1:0]    imm_D,
  input  logic [4:0]         rs1_D,
  input  logic [4:0]         rs2_D,
  input  logic [4:0]         rd_D,
  input  logic               use_rs1_D,
  input  logic               use_rs2_D,
  input  logic [XLEN-1:0]    rdata1_D,
  input  logic [XLEN-1:0]    rdata2_D,
  input  logic               valid_D,
  input  logic               we_reg_D,
  input  logic               mem_rd_D,
  input  logic               mem_wr_D,
  input  logic               alu_src_D,
  input  logic [ALUOP_W-1:0] alu_op_D,
  input  logic [2:0]         funct3_D,
  input  logic [4:0]         rd_W,
  input  logic [XLEN-1:0]    Wdata,
  input  logic               we_reg_W,
  input  logic               stall_E,
  input  logic               flush_E,
  output logic               stall_D,
`ifdef HAZARD_CNT_EN
  output logic [31:0]        lu_cnt,
  output logic [31:0]        flush_cnt,
`endif
  output logic               valid_E,
  output logic [XLEN-1:0]    pc_E,
  output logic [XLEN-1:0]    imm_E,
  output logic [4:0]         rs1_E,
  output logic [4:0]         rs2_E,
  output logic [4:0]         rd_E,
  output logic [XLEN-1:0]    rdata1_E,
  output logic [XLEN-1:0]    rdata2_E,
  output logic               we_reg_E,
  output logic               mem_rd_E,
  output logic               mem_wr_E,
  output logic               alu_src_E,
  output logic [ALUOP_W-1:0] alu_op_E,
  output logic [2:0]         funct3_E
);

  typedef struct packed {
    logic               valid;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    imm;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic [XLEN-1:0]    rdata1;
    logic [XLEN-1:0]    rdata2;
    logic               we_reg;
    logic               mem_rd;
    logic               mem_wr;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
    logic [2:0]         funct3;
  } ex_slot_t;

  ex_slot_t        ex_d, ex_q;
  logic [XLEN-1:0] op1, op2;
  logic            lu;

  // The register file writes at the edge, so a same-cycle writeback must be bypassed; x0 never is.
  assign op1 = (we_reg_W && rd_W != 5'd0 && rd_W == rs1_D) ? Wdata : rdata1_D;
  assign op2 = (we_reg_W && rd_W != 5'd0 && rd_W == rs2_D) ? Wdata : rdata2_D;

  assign lu = ex_q.valid && ex_q.mem_rd && ex_q.rd != 5'd0 && valid_D &&
              ((use_rs1_D && rs1_D == ex_q.rd) || (use_rs2_D && rs2_D == ex_q.rd));

  assign stall_D = (lu || stall_E) && !flush_E;

  always_comb begin
    // NOTE: default assignment first so every path assigns ex_d and no latch is inferred.
    ex_d = ex_q;
    if (flush_E) begin
      ex_d = '0;
    end else if (stall_E) begin
      ex_d = ex_q;
    end else if (lu) begin
      ex_d = '0;
    end else begin
      ex_d.valid   = valid_D;
      ex_d.pc      = pc_D;
      ex_d.imm     = imm_D;
      ex_d.rs1     = rs1_D;
      ex_d.rs2     = rs2_D;
      ex_d.rd      = rd_D;
      ex_d.rdata1  = op1;
      ex_d.rdata2  = op2;
      ex_d.we_reg  = we_reg_D;
      ex_d.mem_rd  = mem_rd_D;
      ex_d.mem_wr  = mem_wr_D;
      ex_d.alu_src = alu_src_D;
      ex_d.alu_op  = alu_op_D;
      ex_d.funct3  = funct3_D;
      if (!valid_D) begin
        ex_d.valid  = 1'b0;
        ex_d.we_reg = 1'b0;
        ex_d.mem_rd = 1'b0;
        ex_d.mem_wr = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment for state so every flop samples pre-edge values.
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  assign valid_E   = ex_q.valid;
  assign pc_E      = ex_q.pc;
  assign imm_E     = ex_q.imm;
  assign rs1_E     = ex_q.rs1;
  assign rs2_E     = ex_q.rs2;
  assign rd_E      = ex_q.rd;
  assign rdata1_E  = ex_q.rdata1;
  assign rdata2_E  = ex_q.rdata2;
  assign we_reg_E  = ex_q.we_reg;
  assign mem_rd_E  = ex_q.mem_rd;
  assign mem_wr_E  = ex_q.mem_wr;
  assign alu_src_E = ex_q.alu_src;
  assign alu_op_E  = ex_q.alu_op;
  assign funct3_E  = ex_q.funct3;

`ifdef HAZARD_CNT_EN
  logic [31:0] lu_cnt_d, lu_cnt_q, flush_cnt_d, flush_cnt_q;

  // A load-use bubble only counts when it is actually inserted (not masked by flush or stall).
  always_comb begin
    lu_cnt_d    = lu_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (flush_E)              flush_cnt_d = flush_cnt_q + 32'd1;
    else if (!stall_E && lu)  lu_cnt_d    = lu_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lu_cnt_q    <= '0;
      flush_cnt_q <= '0;
    end else begin
      lu_cnt_q    <= lu_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign lu_cnt    = lu_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: reference model feeds a scoreboard queue of expected E slots.
// Counter checks are included when HAZARD_CNT_EN is defined.
module tb_id_ex_stage;
  localparam int XLEN    = 32;
  localparam int ALUOP_W = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [XLEN-1:0]    pc_D, imm_D, rdata1_D, rdata2_D, Wdata;
  logic [4:0]         rs1_D, rs2_D, rd_D, rd_W;
  logic               use_rs1_D, use_rs2_D, valid_D, we_reg_D, mem_rd_D, mem_wr_D, alu_src_D;
  logic [ALUOP_W-1:0] alu_op_D;
  logic [2:0]         funct3_D;
  logic               we_reg_W, stall_E, flush_E, stall_D;
  logic               valid_E, we_reg_E, mem_rd_E, mem_wr_E, alu_src_E;
  logic [XLEN-1:0]    pc_E, imm_E, rdata1_E, rdata2_E;
  logic [4:0]         rs1_E, rs2_E, rd_E;
  logic [ALUOP_W-1:0] alu_op_E;
  logic [2:0]         funct3_E;
`ifdef HAZARD_CNT_EN
  logic [31:0]        lu_cnt, flush_cnt;
  logic [31:0]        m_lu_cnt, m_flush_cnt;
`endif

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .ALUOP_W(ALUOP_W)) dut (
    .clk(clk), .rst(rst),
    .pc_D(pc_D), .imm_D(imm_D), .rs1_D(rs1_D), .rs2_D(rs2_D), .rd_D(rd_D),
    .use_rs1_D(use_rs1_D), .use_rs2_D(use_rs2_D), .rdata1_D(rdata1_D), .rdata2_D(rdata2_D),
    .valid_D(valid_D), .we_reg_D(we_reg_D), .mem_rd_D(mem_rd_D), .mem_wr_D(mem_wr_D),
    .alu_src_D(alu_src_D), .alu_op_D(alu_op_D), .funct3_D(funct3_D),
    .rd_W(rd_W), .Wdata(Wdata), .we_reg_W(we_reg_W), .stall_E(stall_E), .flush_E(flush_E),
    .stall_D(stall_D),
`ifdef HAZARD_CNT_EN
    .lu_cnt(lu_cnt), .flush_cnt(flush_cnt),
`endif
    .valid_E(valid_E), .pc_E(pc_E), .imm_E(imm_E), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
    .rdata1_E(rdata1_E), .rdata2_E(rdata2_E), .we_reg_E(we_reg_E), .mem_rd_E(mem_rd_E),
    .mem_wr_E(mem_wr_E), .alu_src_E(alu_src_E), .alu_op_E(alu_op_E), .funct3_E(funct3_E)
  );

  typedef struct packed {
    logic               valid;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    imm;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic [XLEN-1:0]    rdata1;
    logic [XLEN-1:0]    rdata2;
    logic               we_reg;
    logic               mem_rd;
    logic               mem_wr;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
    logic [2:0]         funct3;
  } e_t;

  e_t   dut_e;
  e_t   m_e;
  e_t   exp_q[$];
  logic m_known = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  assign dut_e = {valid_E, pc_E, imm_E, rs1_E, rs2_E, rd_E, rdata1_E, rdata2_E,
                  we_reg_E, mem_rd_E, mem_wr_E, alu_src_E, alu_op_E, funct3_E};

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_d(input logic v, input logic [31:0] pc, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input logic u1, input logic u2, input logic [31:0] d1,
                         input logic [31:0] d2, input logic we, input logic mrd, input logic mwr);
    valid_D = v; pc_D = pc; imm_D = pc ^ 32'h5A5A_0000; rs1_D = r1; rs2_D = r2; rd_D = rd;
    use_rs1_D = u1; use_rs2_D = u2; rdata1_D = d1; rdata2_D = d2;
    we_reg_D = we; mem_rd_D = mrd; mem_wr_D = mwr;
    alu_src_D = pc[2]; alu_op_D = pc[7:4]; funct3_D = pc[10:8];
  endtask

  task automatic drive_w(input logic we, input logic [4:0] rd, input logic [31:0] d);
    we_reg_W = we; rd_W = rd; Wdata = d;
  endtask

  // One clock: model the next E slot, queue it, check stall_D, then pop and compare after the edge.
  task automatic cycle(input string tag);
    e_t          nxt;
    e_t          got;
    logic [31:0] o1, o2;
    logic        lu_m, stall_m;
    o1 = (we_reg_W && rd_W != 0 && rd_W == rs1_D) ? Wdata : rdata1_D;
    o2 = (we_reg_W && rd_W != 0 && rd_W == rs2_D) ? Wdata : rdata2_D;
    lu_m = m_e.valid && m_e.mem_rd && (m_e.rd != 0) && valid_D &&
           ((use_rs1_D && rs1_D == m_e.rd) || (use_rs2_D && rs2_D == m_e.rd));
    stall_m = (lu_m || stall_E) && !flush_E;
    if (rst || flush_E)  nxt = '0;
    else if (stall_E)    nxt = m_e;
    else if (lu_m)       nxt = '0;
    else begin
      nxt = '{valid: valid_D, pc: pc_D, imm: imm_D, rs1: rs1_D, rs2: rs2_D, rd: rd_D,
              rdata1: o1, rdata2: o2, we_reg: we_reg_D && valid_D, mem_rd: mem_rd_D && valid_D,
              mem_wr: mem_wr_D && valid_D, alu_src: alu_src_D, alu_op: alu_op_D, funct3: funct3_D};
    end
`ifdef HAZARD_CNT_EN
    if (rst)                        begin m_lu_cnt = 0; m_flush_cnt = 0; end
    else if (flush_E)               m_flush_cnt = m_flush_cnt + 1;
    else if (!stall_E && lu_m)      m_lu_cnt = m_lu_cnt + 1;
`endif
    #1;
    if (m_known) check({tag, "/stall_D"}, {191'd0, stall_D}, {191'd0, stall_m});
    exp_q.push_back(nxt);
    @(posedge clk);
    #1;
    m_e     = nxt;
    m_known = 1'b1;
    got = exp_q.pop_front();
    check({tag, "/E"}, {37'd0, dut_e}, {37'd0, got});
`ifdef HAZARD_CNT_EN
    check({tag, "/lu_cnt"}, {160'd0, lu_cnt}, {160'd0, m_lu_cnt});
    check({tag, "/flush_cnt"}, {160'd0, flush_cnt}, {160'd0, m_flush_cnt});
`endif
  endtask

  initial begin
    rst = 1'b1; stall_E = 1'b0; flush_E = 1'b0;
    drive_w(1'b1, 5'd7, 32'hDEAD_BEEF);
    drive_d(1'b1, 32'h0000_0444, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'h1111, 32'h2222, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;

    // Reset with nonzero D inputs.
    cycle("reset0");
    cycle("reset1");
    check("reset/valid_E", {191'd0, valid_E}, 192'd0);

    // First instruction after reset.
    rst = 1'b0;
    drive_w(1'b0, 5'd0, 32'h0);
    drive_d(1'b1, 32'h100, 5'd1, 5'd2, 5'd4, 1'b1, 1'b1, 32'd5, 32'd9, 1'b1, 1'b0, 1'b0);
    cycle("first");
    check("first/pc_E", {160'd0, pc_E}, {160'd0, 32'h100});
    check("first/rdata1_E", {160'd0, rdata1_E}, {160'd0, 32'd5});

    // Writeback bypass, then x0 is never bypassed.
    drive_w(1'b1, 5'd3, 32'hABCD);
    drive_d(1'b1, 32'h104, 5'd3, 5'd2, 5'd4, 1'b1, 1'b0, 32'h11, 32'h22, 1'b1, 1'b0, 1'b0);
    cycle("bypass");
    check("bypass/rdata1_E", {160'd0, rdata1_E}, {160'd0, 32'hABCD});
    drive_w(1'b1, 5'd0, 32'hABCD);
    drive_d(1'b1, 32'h108, 5'd0, 5'd2, 5'd4, 1'b1, 1'b0, 32'h0, 32'h22, 1'b1, 1'b0, 1'b0);
    cycle("bypass_x0");
    check("bypass_x0/rdata1_E", {160'd0, rdata1_E}, 192'd0);

    // Load-use: lw x5, then add reading x5 via rs2 -> one bubble, then bypassed retry.
    drive_w(1'b0, 5'd0, 32'h0);
    drive_d(1'b1, 32'h10C, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b1, 1'b0);
    cycle("lw");
    drive_d(1'b1, 32'h110, 5'd6, 5'd5, 5'd8, 1'b1, 1'b1, 32'h6, 32'h77, 1'b1, 1'b0, 1'b0);
    cycle("lu_bubble");
    check("lu_bubble/valid_E", {191'd0, valid_E}, 192'd0);
    drive_w(1'b1, 5'd5, 32'h5555);
    cycle("lu_retry");
    check("lu_retry/rdata2_E", {160'd0, rdata2_E}, {160'd0, 32'h5555});
    check("lu_retry/stall_D", {191'd0, stall_D}, 192'd0);

    // Flush coinciding with a load-use hazard: flush wins.
    drive_w(1'b0, 5'd0, 32'h0);
    drive_d(1'b1, 32'h114, 5'd1, 5'd0, 5'd6, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b1, 1'b0);
    cycle("lw6");
    flush_E = 1'b1;
    drive_d(1'b1, 32'h118, 5'd6, 5'd0, 5'd9, 1'b1, 1'b0, 32'h66, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle("flush_lu");
    flush_E = 1'b0;

    // Execute stall for three cycles with changing D inputs, then release.
    drive_d(1'b1, 32'h200, 5'd2, 5'd3, 5'd10, 1'b1, 1'b1, 32'hA0, 32'hB0, 1'b1, 1'b0, 1'b1);
    cycle("pre_stall");
    stall_E = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_d(1'b1, 32'h300 + 4 * i, 5'(i + 11), 5'd12, 5'd13, 1'b1, 1'b1, $urandom, $urandom, 1'b1, 1'b0, 1'b0);
      cycle("stall_E");
      check("stall_E/pc_E", {160'd0, pc_E}, {160'd0, 32'h200});
    end
    stall_E = 1'b0;
    cycle("stall_release");
    check("stall_release/pc_E", {160'd0, pc_E}, {160'd0, 32'h308});

    // Random traffic with a small register space to provoke hazards and bypasses.
    for (int i = 0; i < 200; i++) begin
      drive_d(1'($urandom), $urandom, 5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)),
              5'($urandom_range(0, 4)), 1'($urandom), 1'($urandom), $urandom, $urandom,
              1'($urandom), 1'($urandom), 1'($urandom));
      drive_w(1'($urandom), 5'($urandom_range(0, 4)), $urandom);
      stall_E = ($urandom_range(0, 7) == 0);
      flush_E = ($urandom_range(0, 9) == 0);
      cycle("random");
    end
    stall_E = 1'b0; flush_E = 1'b0;

`ifdef HAZARD_CNT_EN
    // Counter wrap: preload lu_cnt to all ones, then one more bubble wraps to 0.
    drive_w(1'b0, 5'd0, 32'h0);
    drive_d(1'b1, 32'h400, 5'd1, 5'd0, 5'd7, 1'b1, 1'b0, 32'h1, 32'h0, 1'b1, 1'b1, 1'b0);
    cycle("wrap_lw");
    force dut.lu_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.lu_cnt_q;
    m_lu_cnt = 32'hFFFF_FFFF;
    drive_d(1'b1, 32'h404, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 32'h2, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle("wrap_lu");
    check("wrap/lu_cnt_zero", {160'd0, lu_cnt}, 192'd0);
`endif

    if (exp_q.size() != 0) check("scoreboard_drain", 192'(exp_q.size()), 192'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
